// File: rtl/crc32_stream_acc.sv
// CRC-32 (IEEE 802.3, reflected) accumulator for packetised streams.
// Generates the FCS or, in check mode, flags a good residue over data+FCS.
//
//   state  | meaning
//   -------+--------------------------------------------------------
//   IDLE   | between packets; only a sop beat is accepted
//   IN_PKT | packet open; beats accumulate until eop
//
// Pipeline: S1 input register, S2 data-side XOR partial sums (G) with the
// eop byte-count variant already selected, S3 CRC state update (F ^ G).
// The output register loads from the S3 next-state value, so an eop beat
// in cycle N strobes crc_valid in cycle N+3.
module crc32_stream_acc #(
   parameter int DATA_BYTES  = 8,
   parameter int CHECK_MODE  = 0,
   parameter int TARGET_CHIP = 2,
   localparam int EMPTY_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
   input  logic                      clk,
   input  logic                      arst,
   input  logic                      in_valid,
   input  logic                      in_sop,
   input  logic                      in_eop,
   input  logic [EMPTY_W-1:0]        in_empty,
   input  logic [8*DATA_BYTES-1:0]   in_data,
   output logic                      crc_valid,
   output logic [31:0]               crc_out,
   output logic                      crc_ok,
   output logic                      proto_err
);
   localparam int DW    = 8 * DATA_BYTES;
   localparam int KW    = $clog2(DATA_BYTES + 1);
   // Two partial sums when the beat is wider than a byte; the target
   // selects whether the data tree is split across the S2 register.
   localparam int NPART = (DATA_BYTES > 1 && TARGET_CHIP >= 2) ? 2 : 1;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] RESIDUE  = 32'h2144_DF1C;

   typedef enum logic {IDLE, IN_PKT} state_t;

   state_t            state, state_nxt;
   logic              accept, start, perr_nxt;
   logic [KW-1:0]     k_in;

   logic              v1, sop1, eop1;
   logic [KW-1:0]     k1;
   logic [DW-1:0]     d1;
   logic [31:0]       g_sel [NPART];

   logic              v2, sop2, eop2;
   logic [KW-1:0]     k2;
   logic [31:0]       gp2 [NPART];

   logic [31:0]       crc_state, base, g_sum, f_adv, crc_nxt;

   // Advance reflected CRC state s by n bytes of d (byte 0 first).
   function automatic logic [31:0] crc_adv(input logic [31:0] s, input logic [DW-1:0] d,
                                           input int n);
      logic [31:0] c;
      c = s;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (i < n) begin
            c = c ^ {24'h0, d[8*i +: 8]};
            for (int b = 0; b < 8; b++)
               c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return c;
   endfunction

   // Byte lanes belonging to partial sum p.
   function automatic logic [DW-1:0] part_mask(input int p);
      logic [DW-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_BYTES; i++)
         if ((i * NPART) / DATA_BYTES == p) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   // Framing state register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Framing decisions: accept, restart on sop, flag violations.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      start     = 1'b0;
      perr_nxt  = 1'b0;
      if (in_valid) begin
         case (state)
            IDLE: begin
               if (in_sop) begin
                  accept = 1'b1;
                  start  = 1'b1;
                  if (!in_eop) state_nxt = IN_PKT;
               end else begin
                  perr_nxt = 1'b1;
               end
            end
            IN_PKT: begin
               accept   = 1'b1;
               start    = in_sop;
               perr_nxt = in_sop;
               if (in_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Bytes this beat contributes: full width unless it is the eop beat.
   always_comb begin
      k_in = KW'(DATA_BYTES);
      if (in_eop) begin
         if (int'(in_empty) >= DATA_BYTES) k_in = '0;
         else                              k_in = KW'(DATA_BYTES - int'(in_empty));
      end
   end

   // S1: register accepted beat and its controls.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         v1 <= 1'b0; sop1 <= 1'b0; eop1 <= 1'b0; k1 <= '0; d1 <= '0;
      end else begin
         v1 <= accept;
         if (accept) begin
            sop1 <= start;
            eop1 <= in_eop;
            k1   <= k_in;
            d1   <= in_data;
         end
      end
   end

   // Data-side contribution G for the selected byte count, per partial.
   always_comb begin
      for (int p = 0; p < NPART; p++) begin
         g_sel[p] = '0;
         for (int k = 0; k <= DATA_BYTES; k++)
            if (k1 == KW'(k)) g_sel[p] = crc_adv(32'h0, d1 & part_mask(p), k);
      end
   end

   // S2: register partial XOR sums and controls.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         v2 <= 1'b0; sop2 <= 1'b0; eop2 <= 1'b0; k2 <= '0;
         for (int p = 0; p < NPART; p++) gp2[p] <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            sop2 <= sop1;
            eop2 <= eop1;
            k2   <= k1;
            for (int p = 0; p < NPART; p++) gp2[p] <= g_sel[p];
         end
      end
   end

   // Feedback: init mux, k-byte state advance F, fold in G.
   always_comb begin
      base  = sop2 ? CRC_INIT : crc_state;
      g_sum = '0;
      for (int p = 0; p < NPART; p++) g_sum = g_sum ^ gp2[p];
      f_adv = base;
      for (int k = 0; k <= DATA_BYTES; k++)
         if (k2 == KW'(k)) f_adv = crc_adv(base, {DW{1'b0}}, k);
      crc_nxt = f_adv ^ g_sum;
   end

   // S3 state update and output register (xorout, residue compare).
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         crc_state <= '0;
         crc_valid <= 1'b0;
         crc_out   <= '0;
         crc_ok    <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (v2) crc_state <= crc_nxt;
         crc_valid <= v2 && eop2;
         if (v2 && eop2) crc_out <= ~crc_nxt;
         crc_ok    <= (CHECK_MODE != 0) && v2 && eop2 && ((~crc_nxt) == RESIDUE);
         proto_err <= perr_nxt;
      end
   end
endmodule
